// File: rtl/dac_cfg_seq.sv
// dac_cfg_seq: walks a configuration table and issues spi_cmd write/read
// transactions, with read-back verify, retry, timed delays and abort.
// Revision 1.0
`default_nettype none

module dac_cfg_seq #(
   parameter int TBL_AW     = 6,
   parameter int MAX_RETRY  = 3,
   parameter int GAP_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [TBL_AW-1:0] tbl_index_o,
   input  logic [25:0]       tbl_entry_i,
   output logic              cmd_write_o,
   output logic              cmd_read_o,
   input  logic              cmd_write_ack_i,
   input  logic              cmd_read_ack_i,
   output logic [15:0]       write_addr_o,
   output logic [15:0]       read_addr_o,
   output logic [7:0]        write_data_o,
   input  logic [7:0]        read_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [TBL_AW-1:0] err_index_o,
   output logic [7:0]        err_rdata_o
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_WR     = 4'd3;
   localparam logic [3:0] S_RD     = 4'd4;
   localparam logic [3:0] S_CHECK  = 4'd5;
   localparam logic [3:0] S_DLY    = 4'd6;
   localparam logic [3:0] S_GAP    = 4'd7;
   localparam logic [3:0] S_NEXT   = 4'd8;
   localparam logic [3:0] S_DONE   = 4'd9;
   localparam logic [3:0] S_ERR    = 4'd10;

   localparam logic [1:0]  OP_WR     = 2'b00;
   localparam logic [1:0]  OP_WRVFY  = 2'b01;
   localparam logic [1:0]  OP_DLY    = 2'b10;
   localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

   logic [3:0]        state_q, state_d;
   logic [TBL_AW-1:0] idx_q, idx_d;
   logic [25:0]       entry_q, entry_d;
   logic [23:0]       cnt_q, cnt_d;
   logic [3:0]        retry_q, retry_d;
   logic              retry_pend_q, retry_pend_d;
   logic              abort_pend_q, abort_pend_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [TBL_AW-1:0] err_idx_q, err_idx_d;
   logic [7:0]        err_rdata_q, err_rdata_d;
   logic              abort_seen;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         entry_q      <= '0;
         cnt_q        <= '0;
         retry_q      <= '0;
         retry_pend_q <= 1'b0;
         abort_pend_q <= 1'b0;
         rdata_q      <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_idx_q    <= '0;
         err_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         entry_q      <= entry_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         retry_pend_q <= retry_pend_d;
         abort_pend_q <= abort_pend_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_idx_q    <= err_idx_d;
         err_rdata_q  <= err_rdata_d;
      end
   end

   // An abort during a frame is held until the ack; spi_cmd cannot drop a frame.
   assign abort_seen = abort_pend_q | abort_i;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      entry_d      = entry_q;
      cnt_d        = cnt_q;
      retry_d      = retry_q;
      retry_pend_d = retry_pend_q;
      abort_pend_d = abort_pend_q;
      rdata_d      = rdata_q;
      done_d       = done_q;
      error_d      = error_q;
      err_idx_d    = err_idx_q;
      err_rdata_d  = err_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               idx_d        = '0;
               retry_d      = '0;
               retry_pend_d = 1'b0;
               abort_pend_d = 1'b0;
               done_d       = 1'b0;
               error_d      = 1'b0;
               state_d      = S_FETCH;
            end
         end
         S_FETCH: state_d = abort_i ? S_IDLE : S_DECODE;
         S_DECODE: begin
            entry_d = tbl_entry_i;
            cnt_d   = tbl_entry_i[23:0];
            case (tbl_entry_i[25:24])
               OP_WR, OP_WRVFY: state_d = S_WR;
               OP_DLY:          state_d = (tbl_entry_i[23:0] == '0) ? S_NEXT : S_DLY;
               default:         state_d = S_DONE;
            endcase
         end
         S_WR: begin
            if (abort_i) abort_pend_d = 1'b1;
            if (cmd_write_ack_i) begin
               cnt_d = GAP_LOAD;
               if (abort_seen)                          state_d = S_IDLE;
               else if (entry_q[25:24] == OP_WRVFY)     state_d = S_RD;
               else                                     state_d = S_GAP;
            end
         end
         S_RD: begin
            if (abort_i) abort_pend_d = 1'b1;
            if (cmd_read_ack_i) begin
               rdata_d = read_data_i;
               state_d = abort_seen ? S_IDLE : S_CHECK;
            end
         end
         S_CHECK: begin
            cnt_d = GAP_LOAD;
            if (rdata_q == entry_q[7:0]) begin
               retry_pend_d = 1'b0;
               state_d      = S_GAP;
            end else if (retry_q < RETRY_MAX) begin
               retry_d      = retry_q + 4'd1;
               retry_pend_d = 1'b1;
               state_d      = S_GAP;
            end else begin
               err_idx_d   = idx_q;
               err_rdata_d = rdata_q;
               state_d     = S_ERR;
            end
         end
         S_DLY: begin
            if (abort_i)             state_d = S_IDLE;
            else if (cnt_q == 24'd1) state_d = S_NEXT;
            else                     cnt_d   = cnt_q - 24'd1;
         end
         S_GAP: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               retry_pend_d = 1'b0;
               state_d      = retry_pend_q ? S_WR : S_NEXT;
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         S_NEXT: begin
            retry_d = '0;
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (&idx_q) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            error_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_write_o  = (state_q == S_WR);
      cmd_read_o   = (state_q == S_RD);
      busy_o       = (state_q != S_IDLE);
      tbl_index_o  = idx_q;
      write_addr_o = entry_q[23:8];
      read_addr_o  = entry_q[23:8];
      write_data_o = entry_q[7:0];
      done_o       = done_q;
      error_o      = error_q;
      err_index_o  = err_idx_q;
      err_rdata_o  = err_rdata_q;
   end

endmodule

`default_nettype wire

// File: doc/dac_cfg_seq.md
# dac_cfg_seq

Register-initialisation sequencer that sits directly upstream of the SPI command engine (`spi_cmd`) in the DAC control path. It walks an external configuration table and, for each entry, drives `spi_cmd`'s read/write command interface one transaction at a time. Entry types are plain write, write with read-back verify, timed delay, and end-of-table. Verify mismatches are retried a bounded number of times before the sequence halts with an error report.

## Interface
- `TBL_AW`, 6, table index width; the table holds up to 2^TBL_AW entries.
- `MAX_RETRY`, 3, extra write+verify attempts allowed after the first mismatch (range 0..15).
- `GAP_CYCLES`, 16, idle `clk` cycles inserted after each SPI acknowledge before the next entry is fetched (minimum 1).

- `clk` in 1: single clock; all logic runs on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a sequence at index 0; ignored while `busy`=1.
- `abort` in 1: stops the sequence at the next command boundary.
- `tbl_index` out TBL_AW: table read address.
- `tbl_entry` in 26: table entry, valid exactly 1 cycle after `tbl_index` changes. Fields: op[25:24], addr[23:8], data[7:0].
  - op 00 = write.
  - op 01 = write + verify.
  - op 10 = delay for {addr,data} cycles.
  - op 11 = end of table.
- `cmd_write` out 1: write request to `spi_cmd`; held high until the acknowledge is seen.
- `cmd_read` out 1: read request to `spi_cmd`; held high until the acknowledge is seen.
- `cmd_write_ack` in 1: one-cycle acknowledge from `spi_cmd`.
- `cmd_read_ack` in 1: one-cycle acknowledge from `spi_cmd`; `read_data` is valid in the same cycle.
- `write_addr` out 16: address for the write command.
- `read_addr` out 16: address for the read command.
- `write_data` out 8: data for the write command.
- `read_data` in 8: read-back byte from `spi_cmd`.
- `busy` out 1: high from the cycle after `start` until the DONE/ERR/IDLE return.
- `done` out 1: sticky; set on a successful end; cleared by the next accepted `start`.
- `error` out 1: sticky; set when verify retries are exhausted; cleared by the next accepted `start`.
- `err_index` out TBL_AW: index of the entry that failed verify.
- `err_rdata` out 8: last read-back byte of the failing entry.

## Operation

**Reset values.** All outputs are 0 and the state is IDLE.

**States and transitions.**
- IDLE: on `start`, set `tbl_index`←0, retry←0, clear `done`/`error`, go to FETCH.
- FETCH: wait one cycle for table latency, then go to DECODE.
- DECODE: latch `tbl_entry`.
  - op00/op01 → WR.
  - op10 → DLY with count←{addr,data}. A count of 0 goes straight to NEXT.
  - op11 → DONE.
- WR: `cmd_write`=1 (decoded from state) with `write_addr`/`write_data` driven from the latched entry. On `cmd_write_ack`: op01 → RD, otherwise → GAP.
- RD: `cmd_read`=1 with `read_addr`=entry addr. On `cmd_read_ack`, capture `read_data` and go to CHECK.
- CHECK:
  - Captured byte equals entry data → GAP.
  - Mismatch with retry<MAX_RETRY → retry+1, go to GAP, then back to WR for the same entry.
  - Mismatch otherwise → ERR. Load `err_index` and `err_rdata`.
- DLY: decrement each cycle; at 1 → NEXT.
- GAP: count GAP_CYCLES, then → WR (if a retry is pending) or NEXT.
- NEXT: retry←0.
  - If `tbl_index` equals all ones → DONE (wrap-around counts as the end of the table).
  - Otherwise `tbl_index`+1 → FETCH.
- DONE: `done`←1, go to IDLE.
- ERR: `error`←1, go to IDLE.

**Abort.** `abort` is sampled in FETCH, DLY, GAP and NEXT and forces IDLE with `done`/`error` unchanged. In WR and RD the abort is remembered and takes effect after the acknowledge, because `spi_cmd` cannot abandon a frame in progress.

**Boundary rules.**
- Only one of `cmd_read`/`cmd_write` is ever high at a time.
- Both requests are low in the cycle after their acknowledge. This prevents `spi_cmd` from re-triggering after its CE-high period.
- `start` coincident with `abort` in IDLE: `start` wins.
- Acknowledges arriving outside WR/RD are ignored.
- `rst_n` low in any state returns to IDLE immediately with outputs zeroed. `spi_cmd` is reset by the same net.

## Timing
- `start` accepted at edge 0; FETCH occupies cycle 1; DECODE cycle 2.
- `cmd_write` goes high in cycle 3.
- Ack at cycle k: the request is low at cycle k+1, and GAP runs cycles k+1..k+GAP_CYCLES.
- Per-entry overhead excluding SPI time: 3 + GAP_CYCLES cycles (write) or 4 + GAP_CYCLES cycles (verify, including CHECK).
- `busy` rises in the cycle after `start` and falls in the cycle after DONE/ERR.

## Test plan
- Table {00,0x0012,0xA5}, {11}; ack model answers after 40 cycles. Expect:
  - one write with addr 0x0012, data 0xA5;
  - `cmd_write` high from cycle 3 until the ack, low on the next cycle;
  - `done`=1, `error`=0.
- Verify pass: entry {01,0x0105,0x3C} with model read_data=0x3C. Expect one write, one read at addr 0x0105, then done.
- Verify fail with MAX_RETRY=3: model always returns 0x00 for expected 0x3C at index 2. Expect:
  - 4 write/read pairs;
  - `error`=1, `err_index`=2, `err_rdata`=0x00, `done`=0.
- Delay entry {10,0x0000,0x64}. Expect exactly 100 DLY cycles between the preceding GAP end and the next FETCH; a 0-count entry adds 0 cycles.
- `abort` asserted mid-WR. Expect:
  - the request is held until the ack;
  - IDLE in the cycle after GAP-entry would have occurred;
  - no further commands;
  - `start` during `busy` is ignored.
- Table with no op11 entry and TBL_AW=2. Expect 4 writes and then done (index wrap). `rst_n` pulsed mid-RD zeroes all outputs asynchronously.
